// File: rtl/ssf_pkg.sv
// Shared widths, flag encodings and the wide-to-32-bit saturation helper for
// the slot-filter block.
package ssf_pkg;

    localparam int DATA_W = 32;
    localparam int FLAG_W = 2;
    localparam int SAT_W  = 64;

    localparam logic [FLAG_W-1:0] FLAG_IDLE = 2'd0;
    localparam logic [FLAG_W-1:0] FLAG_ACT  = 2'd1;

    localparam logic signed [SAT_W-1:0] SAT_MAX = 64'sh0000_0000_7FFF_FFFF;
    localparam logic signed [SAT_W-1:0] SAT_MIN = 64'shFFFF_FFFF_8000_0000;

    // Clamp a sign-extended wide value into the signed 32-bit range.
    function automatic logic [DATA_W-1:0] saturate(input logic signed [SAT_W-1:0] v);
        logic [DATA_W-1:0] r;
        if (v > SAT_MAX) begin
            r = SAT_MAX[DATA_W-1:0];
        end else if (v < SAT_MIN) begin
            r = SAT_MIN[DATA_W-1:0];
        end else begin
            r = v[DATA_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/ssf_tapline.sv
// NTAPS-deep sample delay line with load enable and a full-precision signed
// sum of all taps (no intermediate wrap).
module ssf_tapline #(
    parameter int NTAPS  = 8,
    parameter int DATA_W = 32
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              load_i,
    input  logic [DATA_W-1:0]                 sample_i,
    output logic [DATA_W+$clog2(NTAPS)-1:0]   sum_o
);

    localparam int LOG_N = $clog2(NTAPS);
    localparam int SUM_W = DATA_W + LOG_N;

    logic [DATA_W-1:0] tap_q [NTAPS];
    logic [SUM_W-1:0]  acc;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < NTAPS; k++) begin
                tap_q[k] <= '0;
            end
        end else if (load_i) begin
            tap_q[0] <= sample_i;
            for (int k = 1; k < NTAPS; k++) begin
                tap_q[k] <= tap_q[k-1];
            end
        end
    end

    // Each tap is sign-extended to the sum width before accumulation.
    always_comb begin
        acc = '0;
        for (int k = 0; k < NTAPS; k++) begin
            acc = acc + {{LOG_N{tap_q[k][DATA_W-1]}}, tap_q[k]};
        end
    end

    assign sum_o = acc;

endmodule

// File: rtl/ssf_slot_filter.sv
// Time-slotted sum filter: one sample request and one output strobe per frame,
// each lasting a single cycle, decoded purely from registered state.
module ssf_slot_filter
    import ssf_pkg::*;
#(
    parameter int PERIOD    = 32395,
    parameter int OUT_DELAY = 4,
    parameter int NTAPS     = 8,
    parameter int SHIFT     = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   io_in,
    output logic [DATA_W-1:0]   io_out,
    output logic [FLAG_W-1:0]   req_in,
    output logic [FLAG_W-1:0]   out_en
);

    localparam int CNT_W = $clog2(PERIOD);
    localparam int SUM_W = DATA_W + $clog2(NTAPS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_OUT  = CNT_W'(OUT_DELAY);
    // OUT_DELAY must be >= 1: the result is captured one edge before its strobe.
    localparam logic [CNT_W-1:0] CNT_CAP  = CNT_W'(OUT_DELAY - 1);

    logic                     run_q, run_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [DATA_W-1:0]        io_out_q, io_out_d;

    logic                     req_hit;
    logic                     out_hit;
    logic                     cap_hit;
    logic [SUM_W-1:0]         sum_raw;
    logic signed [SUM_W-1:0]  sum_s;
    logic signed [SUM_W-1:0]  shifted;
    logic signed [SAT_W-1:0]  shifted_ext;
    logic [DATA_W-1:0]        result;

    assign req_hit = run_q && (cnt_q == '0);
    assign out_hit = run_q && (cnt_q == CNT_OUT);
    assign cap_hit = run_q && (cnt_q == CNT_CAP);

    ssf_tapline #(
        .NTAPS  (NTAPS),
        .DATA_W (DATA_W)
    ) u_tapline (
        .clk_i    (clk),
        .rst_i    (rst),
        .load_i   (req_hit),
        .sample_i (io_in),
        .sum_o    (sum_raw)
    );

    assign sum_s       = sum_raw;
    assign shifted     = sum_s >>> SHIFT;
    assign shifted_ext = {{(SAT_W-SUM_W){shifted[SUM_W-1]}}, shifted};
    assign result      = saturate(shifted_ext);

    // The first edge out of reset only arms the block; counting starts after.
    always_comb begin
        run_d    = 1'b1;
        cnt_d    = cnt_q;
        io_out_d = io_out_q;
        if (run_q) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
            if (cap_hit) begin
                io_out_d = result;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q    <= 1'b0;
            cnt_q    <= '0;
            io_out_q <= '0;
        end else begin
            run_q    <= run_d;
            cnt_q    <= cnt_d;
            io_out_q <= io_out_d;
        end
    end

    // Flags are strobes, not handshakes: FLAG_ACT for exactly one cycle in this
    // instance's slot, FLAG_IDLE otherwise; io_out is zero whenever out_en is idle.
    assign req_in = req_hit ? FLAG_ACT : FLAG_IDLE;
    assign out_en = out_hit ? FLAG_ACT : FLAG_IDLE;
    assign io_out = out_hit ? io_out_q : '0;

endmodule

// File: tb/tb_ssf_slot_filter.sv
// Directed bench for ssf_slot_filter: a mean-filter instance and a SHIFT=0
// instance for saturation, checked cycle by cycle against a reference model.
module tb_ssf_slot_filter;

  localparam int PERIOD    = 40;
  localparam int OUT_DELAY = 4;
  localparam int NTAPS     = 8;

  logic        clk = 1'b0;
  logic        rst0 = 1'b1;
  logic        rst1 = 1'b1;
  logic [31:0] io_in0 = '0;
  logic [31:0] io_in1 = '0;
  logic [31:0] io_out0, io_out1;
  logic [1:0]  req_in0, req_in1, out_en0, out_en1;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q[$];
  longint      m_tap[2][NTAPS];
  int          m_shift[2] = '{3, 0};

  always #5 clk = ~clk;

  ssf_slot_filter #(
    .PERIOD(PERIOD), .OUT_DELAY(OUT_DELAY), .NTAPS(NTAPS), .SHIFT(3)
  ) u_mean (
    .clk(clk), .rst(rst0), .io_in(io_in0),
    .io_out(io_out0), .req_in(req_in0), .out_en(out_en0)
  );

  ssf_slot_filter #(
    .PERIOD(PERIOD), .OUT_DELAY(OUT_DELAY), .NTAPS(NTAPS), .SHIFT(0)
  ) u_sat (
    .clk(clk), .rst(rst1), .io_in(io_in1),
    .io_out(io_out1), .req_in(req_in1), .out_en(out_en1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input int sel, input string tag, input logic [1:0] e_req,
                          input logic [1:0] e_oen, input logic [31:0] e_out);
    if (sel == 0) begin
      chk({tag, ".req_in"}, {30'd0, req_in0}, {30'd0, e_req});
      chk({tag, ".out_en"}, {30'd0, out_en0}, {30'd0, e_oen});
      chk({tag, ".io_out"}, io_out0, e_out);
    end else begin
      chk({tag, ".req_in"}, {30'd0, req_in1}, {30'd0, e_req});
      chk({tag, ".out_en"}, {30'd0, out_en1}, {30'd0, e_oen});
      chk({tag, ".io_out"}, io_out1, e_out);
    end
  endtask

  // Reference: shift the sample in, sum exactly, floor-shift, clamp.
  function automatic logic [31:0] model_push(input int sel, input logic [31:0] s);
    longint sum;
    longint q;
    for (int k = NTAPS - 1; k > 0; k--) m_tap[sel][k] = m_tap[sel][k-1];
    m_tap[sel][0] = longint'($signed(s));
    sum = 0;
    for (int k = 0; k < NTAPS; k++) sum += m_tap[sel][k];
    q = sum >>> m_shift[sel];
    if (q > 64'sd2147483647) q = 64'sd2147483647;
    if (q < -64'sd2147483648) q = -64'sd2147483648;
    return q[31:0];
  endfunction

  // Leaves the bench at the request cycle of the first frame.
  task automatic do_reset(input int sel, input int n);
    if (sel == 0) rst0 = 1'b1; else rst1 = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      chk_outs(sel, "reset_hold", 2'd0, 2'd0, 32'd0);
    end
    for (int k = 0; k < NTAPS; k++) m_tap[sel][k] = 0;
    exp_q.delete();
    if (sel == 0) rst0 = 1'b0; else rst1 = 1'b0;
    chk_outs(sel, "arm_cycle", 2'd0, 2'd0, 32'd0);
    tick();
  endtask

  // One frame starting at cnt==0; abort_at>=0 asserts rst at that cnt.
  task automatic frame(input int sel, input logic [31:0] sample, input int abort_at);
    logic [31:0] e;
    for (int k = 0; k < PERIOD; k++) begin
      if (k == 0) begin
        chk_outs(sel, "req_slot", 2'd1, 2'd0, 32'd0);
        e = model_push(sel, sample);
        if (abort_at < 0) exp_q.push_back(e);
        if (sel == 0) io_in0 = sample; else io_in1 = sample;
      end else if (k == OUT_DELAY) begin
        if (exp_q.size() == 0) begin
          chk_outs(sel, "out_slot_noexp", 2'd1, 2'd1, 32'hDEAD_BEEF);
        end else begin
          chk_outs(sel, "out_slot", 2'd0, 2'd1, exp_q.pop_front());
        end
      end else begin
        chk_outs(sel, "idle_slot", 2'd0, 2'd0, 32'd0);
      end
      if (k != 0) begin
        if (sel == 0) io_in0 = $urandom; else io_in1 = $urandom;
      end
      if (k == abort_at) begin
        if (sel == 0) rst0 = 1'b1; else rst1 = 1'b1;
        tick();
        return;
      end
      tick();
    end
  endtask

  initial begin
    // Reset / startup and mean of a constant input.
    do_reset(0, 5);
    for (int f = 0; f < 11; f++) frame(0, 32'd80, -1);

    // A single -1 sample floors to -1 for NTAPS frames, then 0.
    do_reset(0, 3);
    frame(0, 32'hFFFF_FFFF, -1);
    for (int f = 0; f < 9; f++) frame(0, 32'd0, -1);

    // Mixed-sign random samples including extremes.
    frame(0, 32'h7FFF_FFFF, -1);
    frame(0, 32'h8000_0000, -1);
    for (int f = 0; f < 3; f++) frame(0, $urandom, -1);
    for (int f = 0; f < 2; f++) frame(0, 32'($urandom_range(0, 1000)) - 32'd500, -1);

    // Mid-frame reset at cnt==2: no strobe, taps cleared.
    frame(0, 32'd1234, 2);
    do_reset(0, 2);
    frame(0, 32'd800, -1);
    frame(0, 32'd0, -1);

    // Saturation with SHIFT=0, both directions.
    do_reset(1, 5);
    frame(1, 32'h7FFF_FFFF, -1);
    frame(1, 32'h7FFF_FFFF, -1);
    do_reset(1, 2);
    frame(1, 32'h8000_0000, -1);
    frame(1, 32'h8000_0000, -1);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
